reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Integer register file plus scoreboard; the consuming end of the write-back interface driven by WB_Stage.
//  Holds x0..x31 (64-bit) and accepts one write per cycle from WB (RegWriteW/RD_W/WriteData).
//  Serves two async read ports to ID and tracks in-flight writes per register.
//  Stalls ID on a RAW hazard or counter saturation; no forwarding network in this pipeline.
// PARAMETERS
//  XLEN      64  data width of each register
//  NREGS     32  architectural registers; x0 hardwired to zero
//  CNT_W     2   width of per-register in-flight counter (max 2**CNT_W-1 outstanding)
// PORTS
//  clk             in   1      clock, all state updates on rising edge
//  rst             in   1      synchronous reset, active-high
//  RegWriteW       in   1      WB write enable
//  RD_W            in   5      WB destination register
//  WriteData       in   XLEN   WB data
//  RS1_D / RS2_D   in   5      ID source register indices
//  UseRs1D/UseRs2D in   1      ID instruction actually reads rs1 / rs2
//  RD1_D / RD2_D   out  XLEN   read data for rs1 / rs2 (combinational)
//  IssueValidD     in   1      ID holds a valid instruction wanting to advance
//  IssueRegWriteD  in   1      that instruction will write a register
//  IssueRdD        in   5      its destination register
//  StallD          out  1      hold ID/IF; instruction is not accepted this cycle
//  SbErr           out  1      sticky: WB write seen for a register with zero in-flight count
// BEHAVIOUR
//  - Reset: all regs <= 0, all counters <= 0, SbErr <= 0; hence RD1_D=RD2_D=0, StallD=0 after reset.
//  - Clock and reset only; rst mid-operation discards all in-flight tracking; the surrounding pipeline is flushed by the same rst.
//  - Write: posedge clk, RegWriteW && RD_W!=0 -> regs[RD_W] <= WriteData. Writes to x0 are dropped; a read of x0 always returns 0.
//  - Read: RDn_D = regs[RSn_D] combinationally (0 for index 0). Write takes effect the next cycle (see WB_BYPASS_EN).
//  - accept = IssueValidD && !StallD. Issue is squashed externally by deasserting IssueValidD.
//  - inc[r] = accept && IssueRegWriteD && IssueRdD==r && r!=0.
//  - dec[r] = RegWriteW && RD_W==r && r!=0 && cnt[r]!=0.
//  - cnt[r]: inc only -> +1; dec only -> -1; both in the same cycle -> unchanged. Never wraps.
//  - RegWriteW to r!=0 with cnt[r]==0 -> no change to cnt; SbErr <= 1 (sticky until rst). The data write still occurs.
//  - haz(rs) = rs!=0 && cnt[rs]!=0, except when the bypass rule below clears it.
//  - StallD = IssueValidD && ((UseRs1D && haz(RS1_D)) || (UseRs2D && haz(RS2_D))
//             || (IssueRegWriteD && IssueRdD!=0 && cnt[IssueRdD]==2**CNT_W-1)).
//  - Saturation stall holds until WB retires a write to that register; the counter never exceeds its maximum.
//  - Source equal to its own destination (e.g. addi x5,x5,1) is checked against the current count, before that instruction's increment.
//  - StallD is combinational from current state and inputs; no latency beyond that.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//   - RegWriteW && RD_W==RSn_D && RSn_D!=0 -> RDn_D = WriteData in the same cycle.
//   - haz(rs) is forced 0 when cnt[rs]==1 and WB writes rs this cycle, so the consumer issues one cycle earlier.
//  WB_BYPASS_EN undefined:
//   - No write-through; RDn_D shows the old value during the WB cycle.
//   - haz(rs) stays asserted through that cycle, and the consumer issues the cycle after the write.
// TESTING
//  1. rst high 1 cycle -> RD1_D=RD2_D=0, StallD=0, SbErr=0 for all RS1_D/RS2_D values.
//  2. Write x0: RegWriteW=1, RD_W=0, WriteData=64'hDEAD -> RS1_D=0 reads 0, SbErr unchanged.
//  3. Issue rd=5 (cnt 0->1); next cycle ID uses rs1=5 -> StallD=1 until WB writes x5=64'h1234.
//     - With WB_BYPASS_EN: StallD=0 and RD1_D=64'h1234 in the WB cycle.
//     - Without WB_BYPASS_EN: StallD=0 and RD1_D=64'h1234 one cycle later.
//  4. Three accepted issues to rd=7, none retired -> cnt=3; a 4th issue to rd=7 -> StallD=1.
//     - WB write x7 -> cnt=2; the 4th issue is then accepted, cnt back to 3.
//  5. Same cycle: accepted issue to rd=9 and WB write x9, cnt[9]=1 -> cnt stays 1, regs[9] updated.
//  6. WB write x12 with cnt[12]=0 -> SbErr=1 and stays 1; regs[12] updated; only rst clears SbErr.

Source files
------------

// File: rtl/reg_file_sb_if.sv
// Write-back / decode interface of the integer register file + scoreboard.
// master: pipeline side (WB stage and ID stage). slave: register file.
interface reg_file_sb_if #(
    parameter int XLEN = 64
);
    logic            RegWriteW;
    logic [4:0]      RD_W;
    logic [XLEN-1:0] WriteData;
    logic [4:0]      RS1_D;
    logic [4:0]      RS2_D;
    logic            UseRs1D;
    logic            UseRs2D;
    logic [XLEN-1:0] RD1_D;
    logic [XLEN-1:0] RD2_D;
    logic            IssueValidD;
    logic            IssueRegWriteD;
    logic [4:0]      IssueRdD;
    logic            StallD;
    logic            SbErr;

    modport master (
        output RegWriteW, RD_W, WriteData,
        output RS1_D, RS2_D, UseRs1D, UseRs2D,
        output IssueValidD, IssueRegWriteD, IssueRdD,
        input  RD1_D, RD2_D, StallD, SbErr
    );

    modport slave (
        input  RegWriteW, RD_W, WriteData,
        input  RS1_D, RS2_D, UseRs1D, UseRs2D,
        input  IssueValidD, IssueRegWriteD, IssueRdD,
        output RD1_D, RD2_D, StallD, SbErr
    );
endinterface

// File: rtl/reg_file_sb.sv
// Integer register file (x0 hardwired to zero) with a per-register
// in-flight write scoreboard. ID is stalled on RAW hazards and when a
// destination's in-flight counter is saturated; there is no forwarding.
// Optional build macro: WB_BYPASS_EN -- write-through of the WB write to
// the read ports and early hazard release in the WB cycle.
module reg_file_sb #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int CNT_W = 2
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_sb_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]  regs [NREGS];
    logic [CNT_W-1:0] cnt  [NREGS];
    logic             sb_err;

    logic [CNT_W-1:0] cnt_rs1;
    logic [CNT_W-1:0] cnt_rs2;
    logic [CNT_W-1:0] cnt_rd;
    logic [CNT_W-1:0] cnt_wb;
    logic             haz_rs1;
    logic             haz_rs2;
    logic             sat_rd;
    logic             stall;
    logic             accept;
    logic             wb_live;
    logic [NREGS-1:0] inc;
    logic [NREGS-1:0] dec;

    assign wb_live = bus.RegWriteW && (bus.RD_W != 5'd0);
    assign cnt_rs1 = cnt[bus.RS1_D];
    assign cnt_rs2 = cnt[bus.RS2_D];
    assign cnt_rd  = cnt[bus.IssueRdD];
    assign cnt_wb  = cnt[bus.RD_W];

    // Read ports and hazard detection; the same-cycle WB write optionally short-circuits both.
    always_comb begin
        bus.RD1_D = (bus.RS1_D == 5'd0) ? '0 : regs[bus.RS1_D];
        bus.RD2_D = (bus.RS2_D == 5'd0) ? '0 : regs[bus.RS2_D];
        haz_rs1   = (bus.RS1_D != 5'd0) && (cnt_rs1 != '0);
        haz_rs2   = (bus.RS2_D != 5'd0) && (cnt_rs2 != '0);
`ifdef WB_BYPASS_EN
        if (wb_live && (bus.RD_W == bus.RS1_D)) begin
            bus.RD1_D = bus.WriteData;
            if (cnt_rs1 == CNT_W'(1)) haz_rs1 = 1'b0;
        end
        if (wb_live && (bus.RD_W == bus.RS2_D)) begin
            bus.RD2_D = bus.WriteData;
            if (cnt_rs2 == CNT_W'(1)) haz_rs2 = 1'b0;
        end
`endif
    end

    assign sat_rd = bus.IssueRegWriteD && (bus.IssueRdD != 5'd0) && (cnt_rd == CNT_MAX);
    assign stall  = bus.IssueValidD &&
                    ((bus.UseRs1D && haz_rs1) || (bus.UseRs2D && haz_rs2) || sat_rd);
    assign accept = bus.IssueValidD && !stall;

    assign bus.StallD = stall;
    assign bus.SbErr  = sb_err;

    // Per-register increment on accepted issue, decrement on retiring WB write.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 1; r < NREGS; r++) begin
            inc[r] = accept && bus.IssueRegWriteD && (bus.IssueRdD == 5'(r));
            dec[r] = wb_live && (bus.RD_W == 5'(r)) && (cnt[r] != '0);
        end
    end

    // Register data, in-flight counters and the sticky scoreboard error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            if (wb_live) begin
                regs[bus.RD_W] <= bus.WriteData;
                if (cnt_wb == '0) sb_err <= 1'b1;
            end
            for (int r = 1; r < NREGS; r++) begin
                if (inc[r] && !dec[r])      cnt[r] <= cnt[r] + CNT_W'(1);
                else if (dec[r] && !inc[r]) cnt[r] <= cnt[r] - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard-style bench for reg_file_sb: stimulus computes expected outputs
// from a behavioural model and queues them; a negedge monitor pops and compares.
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_sb_if #(.XLEN(64)) bus ();
    reg_file_sb #(.XLEN(64), .NREGS(32), .CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic        stall;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    logic [63:0] m_regs [32];
    int          m_cnt  [32];
    bit          m_err;
    bit          bypass;

    function automatic logic [63:0] m_read(input logic [4:0] rs);
        if (rs == 0) return 64'd0;
        if (bypass && bus.RegWriteW && bus.RD_W == rs) return bus.WriteData;
        return m_regs[rs];
    endfunction

    function automatic bit m_haz(input logic [4:0] rs);
        if (rs == 0 || m_cnt[rs] == 0) return 1'b0;
        if (bypass && m_cnt[rs] == 1 && bus.RegWriteW && bus.RD_W == rs) return 1'b0;
        return 1'b1;
    endfunction

    // One clock cycle: drive, predict, queue, advance model, wait for edge.
    task automatic cyc(input bit r, input bit we, input logic [4:0] rdw, input logic [63:0] wd,
                       input logic [4:0] s1, input logic [4:0] s2, input bit u1, input bit u2,
                       input bit v, input bit irw, input logic [4:0] ird);
        exp_t e;
        bit   acc;
        int   old_cnt [32];
        rst = r;
        bus.RegWriteW = we; bus.RD_W = rdw; bus.WriteData = wd;
        bus.RS1_D = s1; bus.RS2_D = s2; bus.UseRs1D = u1; bus.UseRs2D = u2;
        bus.IssueValidD = v; bus.IssueRegWriteD = irw; bus.IssueRdD = ird;
        e.rd1   = m_read(s1);
        e.rd2   = m_read(s2);
        e.stall = v && ((u1 && m_haz(s1)) || (u2 && m_haz(s2)) ||
                        (irw && ird != 0 && m_cnt[ird] == 3));
        e.err   = m_err;
        exp_q.push_back(e);
        acc = v && !e.stall;
        if (r) begin
            foreach (m_regs[i]) begin m_regs[i] = 0; m_cnt[i] = 0; end
            m_err = 0;
        end else begin
            old_cnt = m_cnt;
            if (we && rdw != 0) begin
                m_regs[rdw] = wd;
                if (old_cnt[rdw] == 0) m_err = 1;
                else m_cnt[rdw] = m_cnt[rdw] - 1;
            end
            if (acc && irw && ird != 0) m_cnt[ird] = m_cnt[ird] + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are combinational, so one expected record per cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.RD1_D !== e.rd1) begin
                failures++;
                $display("FAIL rd1 t=%0t got=%h exp=%h", $time, bus.RD1_D, e.rd1);
            end
            checks++;
            if (bus.RD2_D !== e.rd2) begin
                failures++;
                $display("FAIL rd2 t=%0t got=%h exp=%h", $time, bus.RD2_D, e.rd2);
            end
            checks++;
            if (bus.StallD !== e.stall) begin
                failures++;
                $display("FAIL stall t=%0t got=%b exp=%b", $time, bus.StallD, e.stall);
            end
            checks++;
            if (bus.SbErr !== e.err) begin
                failures++;
                $display("FAIL sb_err t=%0t got=%b exp=%b", $time, bus.SbErr, e.err);
            end
        end
    end

    initial begin
`ifdef WB_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        foreach (m_regs[i]) begin m_regs[i] = 0; m_cnt[i] = 0; end
        m_err = 0;
        rst = 1'b1;
        bus.RegWriteW = 0; bus.RD_W = 0; bus.WriteData = 0;
        bus.RS1_D = 0; bus.RS2_D = 0; bus.UseRs1D = 0; bus.UseRs2D = 0;
        bus.IssueValidD = 0; bus.IssueRegWriteD = 0; bus.IssueRdD = 0;
        @(posedge clk);
        #1;
        // Reset held one cycle (outputs before it are unknown, so not queued), then sweep read ports.
        rst = 1'b0;
        for (int i = 0; i < 32; i++) cyc(0, 0, 0, 0, 5'(i), 5'(31 - i), 1, 1, 1, 0, 0);

        // x0 write dropped.
        cyc(0, 1, 0, 64'hDEAD, 0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);

        // RAW on x5 released by WB write.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5);
        cyc(0, 0, 0, 0, 5, 0, 1, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 5, 0, 1, 0, 1, 0, 0);
        cyc(0, 1, 5, 64'h1234, 5, 0, 1, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 5, 0, 1, 0, 1, 0, 0);

        // Saturation on x7.
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7);
        cyc(0, 1, 7, 64'h77, 0, 0, 0, 0, 1, 1, 7);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7);
        // Self-dependent addi x7,x7: checked against current count.
        cyc(0, 0, 0, 0, 7, 0, 1, 0, 1, 1, 7);

        // Same-cycle issue and retire on x9.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9);
        cyc(0, 1, 9, 64'h9999, 0, 0, 0, 0, 1, 1, 9);
        cyc(0, 0, 0, 0, 9, 9, 1, 1, 1, 0, 0);
        cyc(0, 1, 9, 64'hAAAA, 9, 9, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 9, 9, 1, 1, 1, 0, 0);

        // Stray WB write to x12: sticky error.
        cyc(0, 1, 12, 64'hC0FFEE, 12, 0, 1, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 12, 0, 1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 12, 7, 1, 1, 1, 0, 0);
        idle();

        // Randomized traffic on a narrow register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            bit          r, we, u1, u2, v, irw;
            logic [4:0]  rdw, s1, s2, ird;
            logic [63:0] wd;
            int          pend [$];
            r   = ($urandom_range(0, 299) == 0);
            we  = ($urandom_range(0, 2) == 0);
            pend.delete();
            for (int k = 1; k < 32; k++) if (m_cnt[k] > 0) pend.push_back(k);
            if (pend.size() > 0 && $urandom_range(0, 39) != 0)
                rdw = 5'(pend[$urandom_range(0, pend.size() - 1)]);
            else
                rdw = 5'($urandom_range(0, 7));
            wd  = {$urandom, $urandom};
            s1  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            s2  = 5'($urandom_range(0, 7));
            u1  = $urandom_range(0, 1);
            u2  = $urandom_range(0, 1);
            v   = ($urandom_range(0, 3) != 0);
            irw = ($urandom_range(0, 3) != 0);
            ird = 5'($urandom_range(0, 7));
            cyc(r, we, rdw, wd, s1, s2, u1, u2, v, irw, ird);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
